// File: rtl/fft_gen_pkg.sv
// Shared types, widths and twiddle-ROM elaboration helpers for the SDF FFT rotator family.
package fft_gen_pkg;

   localparam int SIM_DLY = 1;
   localparam int CPLX_W  = 16;

   typedef struct packed {
      logic signed [CPLX_W-1:0] re;
      logic signed [CPLX_W-1:0] im;
   } cplx_t;

   function automatic int prod_w(input int d_w, input int tw_w);
      return d_w + tw_w + 1;
   endfunction

   function automatic int rnd_r(input real v);
      if (v >= 0.0) return $rtoi(v + 0.5);
      return -$rtoi(0.5 - v);
   endfunction

   // Returns {re[31:0], im[31:0]} of W_n^idx scaled by 2^(tw_w-1)-1.
   // The angle is folded into the first quadrant so a short Taylor series stays exact to the LSB.
   function automatic logic [63:0] tw_val(input int idx, input int n, input int tw_w);
      real th, x2, tc, ts, c, s, cr, sr, scale;
      int  quarter, m, q, r, re_i, im_i;
      quarter = n / 4;
      m       = idx % n;
      q       = m / quarter;
      r       = m % quarter;
      th      = 2.0 * 3.14159265358979323846 * $itor(r) / $itor(n);
      x2      = th * th;
      tc      = 1.0;
      ts      = th;
      c       = 1.0;
      s       = th;
      for (int k = 1; k <= 10; k++) begin
         tc = -tc * x2 / $itor((2 * k - 1) * (2 * k));
         ts = -ts * x2 / $itor((2 * k) * (2 * k + 1));
         c  = c + tc;
         s  = s + ts;
      end
      case (q)
         0:       begin cr = c;  sr = s;  end
         1:       begin cr = -s; sr = c;  end
         2:       begin cr = -c; sr = -s; end
         default: begin cr = s;  sr = -c; end
      endcase
      scale = $itor((1 << (tw_w - 1)) - 1);
      re_i  = rnd_r(scale * cr);
      im_i  = rnd_r(-scale * sr);
      return {re_i, im_i};
   endfunction

endpackage

// File: rtl/ftrans_cmul.sv
// Full-precision complex multiplier with a MULT_DLY-deep, clock-enabled register pipe.
module ftrans_cmul
   import fft_gen_pkg::*;
#(
   parameter int D_W      = 16,
   parameter int TW_W     = 16,
   parameter int MULT_DLY = 2,
   localparam int P_W     = prod_w(D_W, TW_W)
) (
   input  logic                  iclk,
   input  logic                  irst_n,
   input  logic                  ice,
   input  logic signed [D_W-1:0]  ar,
   input  logic signed [D_W-1:0]  ai,
   input  logic signed [TW_W-1:0] br,
   input  logic signed [TW_W-1:0] bi,
   output logic signed [P_W-1:0]  prod_re,
   output logic signed [P_W-1:0]  prod_im
);

   logic signed [P_W-1:0] ar_x, ai_x, br_x, bi_x;
   logic signed [P_W-1:0] re_q [MULT_DLY];
   logic signed [P_W-1:0] im_q [MULT_DLY];

   assign ar_x = {{(P_W-D_W){ar[D_W-1]}}, ar};
   assign ai_x = {{(P_W-D_W){ai[D_W-1]}}, ai};
   assign br_x = {{(P_W-TW_W){br[TW_W-1]}}, br};
   assign bi_x = {{(P_W-TW_W){bi[TW_W-1]}}, bi};

   always_ff @(posedge iclk or negedge irst_n) begin
      if (!irst_n) begin
         for (int i = 0; i < MULT_DLY; i++) begin
            re_q[i] <= '0;
            im_q[i] <= '0;
         end
      end else if (ice) begin
         re_q[0] <= ar_x * br_x - ai_x * bi_x;
         im_q[0] <= ar_x * bi_x + ai_x * br_x;
         for (int i = 1; i < MULT_DLY; i++) begin
            re_q[i] <= re_q[i-1];
            im_q[i] <= im_q[i-1];
         end
      end
   end

   assign prod_re = re_q[MULT_DLY-1];
   assign prod_im = im_q[MULT_DLY-1];

endmodule

// File: rtl/ftrans_gen.sv
// Inter-stage twiddle rotator for the radix-2^2 SDF FFT: ROM lookup, complex multiply,
// round-half-up with saturation, sticky per-frame overflow flag.
module ftrans_gen
   import fft_gen_pkg::*;
#(
   parameter int FFT_STG  = 7,
   parameter int D_W      = 16,
   parameter int TW_W     = 16,
   parameter int MULT_DLY = 2
) (
   input  logic               iclk,
   input  logic               irst_n,
   input  logic               ice,
   input  logic               ien,
   input  logic [FFT_STG-1:0] iaddr,
   input  logic               imode,
   input  logic [2*D_W-1:0]   idata,
   output logic               oen,
   output logic [FFT_STG-1:0] oaddr,
   output logic [2*D_W-1:0]   odata,
   output logic               oovf
);

   localparam int N   = 1 << FFT_STG;
   localparam int P_W = prod_w(D_W, TW_W);
   localparam logic signed [P_W-1:0] RND    = {{(P_W-TW_W+1){1'b0}}, 1'b1, {(TW_W-2){1'b0}}};
   localparam logic signed [P_W-1:0] SAT_HI = {{(P_W-D_W+1){1'b0}}, {(D_W-1){1'b1}}};
   localparam logic signed [P_W-1:0] SAT_LO = {{(P_W-D_W+1){1'b1}}, {(D_W-1){1'b0}}};

   logic signed [TW_W-1:0] rom_re [N];
   logic signed [TW_W-1:0] rom_im [N];

   for (genvar g = 0; g < N; g++) begin : g_rom
      localparam logic [63:0] TW = tw_val(g, N, TW_W);
      assign rom_re[g] = TW[32 +: TW_W];
      assign rom_im[g] = TW[0 +: TW_W];
   end

   logic [FFT_STG-1:0]     k_fac, n3_x, rom_idx;
   logic                   mode_q, mode_nxt;
   logic signed [TW_W-1:0] tw_im_sel;

   assign k_fac     = {{(FFT_STG-2){1'b0}}, iaddr[FFT_STG-2], iaddr[FFT_STG-1]};
   assign n3_x      = {2'b00, iaddr[FFT_STG-3:0]};
   assign rom_idx   = k_fac * n3_x;
   // A frame-start sample both latches imode and is rotated with the new value.
   assign mode_nxt  = (ien && iaddr == '0) ? imode : mode_q;
   assign tw_im_sel = mode_nxt ? -rom_im[rom_idx] : rom_im[rom_idx];

   logic                   s0_vld;
   logic [FFT_STG-1:0]     s0_addr;
   logic signed [D_W-1:0]  s0_re, s0_im;
   logic signed [TW_W-1:0] s0_twr, s0_twi;
   logic                   dly_vld  [MULT_DLY];
   logic [FFT_STG-1:0]     dly_addr [MULT_DLY];

   // ien marks a sample valid on any cycle with ice=1; ice=0 freezes every stage, including flags.
   always_ff @(posedge iclk or negedge irst_n) begin
      if (!irst_n) begin
         mode_q  <= 1'b0;
         s0_vld  <= 1'b0;
         s0_addr <= '0;
         s0_re   <= '0;
         s0_im   <= '0;
         s0_twr  <= '0;
         s0_twi  <= '0;
         for (int i = 0; i < MULT_DLY; i++) begin
            dly_vld[i]  <= 1'b0;
            dly_addr[i] <= '0;
         end
      end else if (ice) begin
         mode_q      <= mode_nxt;
         s0_vld      <= ien;
         s0_addr     <= iaddr;
         s0_re       <= idata[2*D_W-1:D_W];
         s0_im       <= idata[D_W-1:0];
         s0_twr      <= rom_re[rom_idx];
         s0_twi      <= tw_im_sel;
         dly_vld[0]  <= s0_vld;
         dly_addr[0] <= s0_addr;
         for (int i = 1; i < MULT_DLY; i++) begin
            dly_vld[i]  <= dly_vld[i-1];
            dly_addr[i] <= dly_addr[i-1];
         end
      end
   end

   logic signed [P_W-1:0] prod_re, prod_im;

   ftrans_cmul #(
      .D_W      (D_W),
      .TW_W     (TW_W),
      .MULT_DLY (MULT_DLY)
   ) u_cmul (
      .iclk    (iclk),
      .irst_n  (irst_n),
      .ice     (ice),
      .ar      (s0_re),
      .ai      (s0_im),
      .br      (s0_twr),
      .bi      (s0_twi),
      .prod_re (prod_re),
      .prod_im (prod_im)
   );

   logic signed [P_W-1:0] rnd_re, rnd_im;
   logic signed [D_W-1:0] sat_re, sat_im;
   logic                  ovf_re, ovf_im;

   always_comb begin
      rnd_re = (prod_re + RND) >>> (TW_W - 1);
      rnd_im = (prod_im + RND) >>> (TW_W - 1);
      ovf_re = (rnd_re > SAT_HI) || (rnd_re < SAT_LO);
      ovf_im = (rnd_im > SAT_HI) || (rnd_im < SAT_LO);
      sat_re = ovf_re ? ((rnd_re > SAT_HI) ? SAT_HI[D_W-1:0] : SAT_LO[D_W-1:0]) : rnd_re[D_W-1:0];
      sat_im = ovf_im ? ((rnd_im > SAT_HI) ? SAT_HI[D_W-1:0] : SAT_LO[D_W-1:0]) : rnd_im[D_W-1:0];
   end

   always_ff @(posedge iclk or negedge irst_n) begin
      if (!irst_n) begin
         oen   <= 1'b0;
         oaddr <= '0;
         odata <= '0;
         oovf  <= 1'b0;
      end else if (ice) begin
         oen   <= dly_vld[MULT_DLY-1];
         oaddr <= dly_addr[MULT_DLY-1];
         if (dly_vld[MULT_DLY-1]) begin
            odata <= {sat_re, sat_im};
            oovf  <= (dly_addr[MULT_DLY-1] == '0) ? (ovf_re | ovf_im) : (oovf | ovf_re | ovf_im);
         end
      end
   end

endmodule

// File: tb/tb_ftrans_gen.sv
// Randomised and directed bench for ftrans_gen against a transaction-level rotation model.
module tb_ftrans_gen;

   localparam int S    = 4;
   localparam int D_W  = 16;
   localparam int TW_W = 16;
   localparam int MD   = 2;
   localparam int L    = MD + 2;
   localparam int N    = 1 << S;
   localparam int EW   = 1 + S + 2 * D_W + 1;

   logic             iclk = 1'b0;
   logic             irst_n = 1'b1;
   logic             ice = 1'b1, ien = 1'b0, imode = 1'b0;
   logic [S-1:0]     iaddr = '0;
   logic [2*D_W-1:0] idata = '0;
   logic             oen, oovf;
   logic [S-1:0]     oaddr;
   logic [2*D_W-1:0] odata;

   int n_vec = 0;
   int n_err = 0;

   ftrans_gen #(.FFT_STG(S), .D_W(D_W), .TW_W(TW_W), .MULT_DLY(MD)) dut (
      .iclk(iclk), .irst_n(irst_n), .ice(ice), .ien(ien), .iaddr(iaddr), .imode(imode),
      .idata(idata), .oen(oen), .oaddr(oaddr), .odata(odata), .oovf(oovf)
   );

   always #5 iclk = ~iclk;

   // ---------------- reference model ----------------
   logic [EW-1:0]    exp_q[$];
   logic             m_mode = 1'b0;
   logic             exp_oen = 1'b0, exp_oovf = 1'b0;
   logic [S-1:0]     exp_oaddr = '0;
   logic [2*D_W-1:0] exp_odata = '0;

   function automatic int rnd(input real v);
      if (v >= 0.0) return $rtoi(v + 0.5);
      return -$rtoi(0.5 - v);
   endfunction

   function automatic longint clamp(input longint v, output bit sat);
      longint hi, lo;
      hi  = (longint'(1) << (D_W - 1)) - 1;
      lo  = -(longint'(1) << (D_W - 1));
      sat = (v > hi) || (v < lo);
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

   // {sat, re, im} of the sample idata at address addr rotated by the (possibly conjugated) twiddle.
   function automatic logic [2*D_W:0] model_rot(input int addr, input bit inv, input int ar, input int ai);
      int     k1, k2, n3, idx;
      real    ang, sc;
      longint br, bi, pr, pim, half, rr, ri;
      bit     s_re, s_im;
      k1   = (addr >> (S - 1)) & 1;
      k2   = (addr >> (S - 2)) & 1;
      n3   = addr % (1 << (S - 2));
      idx  = ((k1 + 2 * k2) * n3) % N;
      ang  = 2.0 * 3.14159265358979323846 * $itor(idx) / $itor(N);
      sc   = $itor((1 << (TW_W - 1)) - 1);
      br   = longint'(rnd(sc * $cos(ang)));
      bi   = longint'(rnd(-sc * $sin(ang)));
      if (inv) bi = -bi;
      pr   = longint'(ar) * br - longint'(ai) * bi;
      pim  = longint'(ar) * bi + longint'(ai) * br;
      half = longint'(1) << (TW_W - 2);
      rr   = clamp((pr + half) >>> (TW_W - 1), s_re);
      ri   = clamp((pim + half) >>> (TW_W - 1), s_im);
      return {s_re | s_im, D_W'(rr), D_W'(ri)};
   endfunction

   always @(posedge iclk or negedge irst_n) begin
      logic [EW-1:0]  e;
      logic [2*D_W:0] r;
      if (!irst_n) begin
         exp_q.delete();
         m_mode    = 1'b0;
         exp_oen   = 1'b0;
         exp_oaddr = '0;
         exp_odata = '0;
         exp_oovf  = 1'b0;
      end else if (ice) begin
         if (ien && iaddr == '0) m_mode = imode;
         r = model_rot(int'(iaddr), m_mode, int'($signed(idata[2*D_W-1:D_W])), int'($signed(idata[D_W-1:0])));
         exp_q.push_back({ien, iaddr, r});
         if (exp_q.size() == L) begin
            e         = exp_q.pop_front();
            exp_oen   = e[EW-1];
            exp_oaddr = e[EW-2 -: S];
            if (e[EW-1]) begin
               exp_odata = e[2*D_W-1:0];
               exp_oovf  = (e[EW-2 -: S] == '0) ? e[2*D_W] : (exp_oovf | e[2*D_W]);
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge iclk);
      #1;
   endtask

   task automatic drive(input bit en, input int addr, input bit md, input int re, input int im);
      ien   = en;
      iaddr = S'(addr);
      imode = md;
      idata = {D_W'(re), D_W'(im)};
   endtask

   task automatic send_one(input int addr, input bit md, input int re, input int im);
      drive(1'b1, addr, md, re, im);
      tick();
      ien = 1'b0;
      repeat (L - 1) tick();
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      irst_n = 1'b0;
      #12;
      n_vec++;
      if ({oen, oaddr, odata, oovf} !== '0) begin
         n_err++;
         $display("FAIL reset_state: got %h want 0", {oen, oaddr, odata, oovf});
      end
      @(negedge iclk);
      irst_n = 1'b1;
      tick();
   endtask

   task automatic test_identity();
      send_one(0, 1'b0, 1000, -500);
      n_vec++;
      if ({oen, oaddr, odata} !== {1'b1, 4'd0, 16'sd1000, -16'sd500}) begin
         n_err++;
         $display("FAIL identity: got oen=%b oaddr=%0d odata=%h want 1 0 %h", oen, oaddr, odata, {16'sd1000, -16'sd500});
      end
      n_vec++;
      if ({oen, oaddr, odata, oovf} !== {exp_oen, exp_oaddr, exp_odata, exp_oovf}) begin
         n_err++;
         $display("FAIL identity_model: got %h want %h", {oen, oaddr, odata, oovf}, {exp_oen, exp_oaddr, exp_odata, exp_oovf});
      end
      tick();
   endtask

   task automatic test_rotate45();
      send_one(10, 1'b0, 1000, 0);
      n_vec++;
      if ({oen, oaddr, odata} !== {1'b1, 4'd10, 16'sd707, -16'sd707}) begin
         n_err++;
         $display("FAIL rot45: got oen=%b oaddr=%0d odata=%h want 1 10 %h", oen, oaddr, odata, {16'sd707, -16'sd707});
      end
      tick();
   endtask

   task automatic test_inverse();
      logic [2*D_W-1:0] got10;
      int pass_md;
      for (int f = 0; f < 2; f++) begin
         pass_md = (f == 0) ? 1 : 0;
         got10 = 'x;
         drive(1'b1, 0, pass_md[0], 0, 0);
         tick();
         drive(1'b1, 5, ~pass_md[0], 0, 0);
         tick();
         drive(1'b1, 10, ~pass_md[0], 1000, 0);
         tick();
         ien = 1'b0;
         for (int c = 0; c < L + 1; c++) begin
            if (oen && oaddr == 4'd10) got10 = odata;
            n_vec++;
            if ({oen, oaddr, odata, oovf} !== {exp_oen, exp_oaddr, exp_odata, exp_oovf}) begin
               n_err++;
               $display("FAIL inverse_model: got %h want %h", {oen, oaddr, odata, oovf}, {exp_oen, exp_oaddr, exp_odata, exp_oovf});
            end
            tick();
         end
         n_vec++;
         if (got10 !== ((f == 0) ? {16'sd707, 16'sd707} : {16'sd707, -16'sd707})) begin
            n_err++;
            $display("FAIL inverse_frame%0d: got %h want %h", f, got10,
                     (f == 0) ? {16'sd707, 16'sd707} : {16'sd707, -16'sd707});
         end
      end
   endtask

   task automatic test_saturation();
      send_one(10, 1'b0, 32767, 32767);
      n_vec++;
      if ({odata, oovf} !== {16'sd32767, 16'sd0, 1'b1}) begin
         n_err++;
         $display("FAIL sat_value: got odata=%h oovf=%b want 7fff0000 1", odata, oovf);
      end
      send_one(3, 1'b0, 100, 100);
      n_vec++;
      if (oovf !== 1'b1) begin
         n_err++;
         $display("FAIL sat_sticky: got oovf=%b want 1", oovf);
      end
      send_one(0, 1'b0, 100, 100);
      n_vec++;
      if (oovf !== 1'b0) begin
         n_err++;
         $display("FAIL sat_clear: got oovf=%b want 0", oovf);
      end
      tick();
   endtask

   task automatic test_stall();
      logic [EW-1:0] held;
      int seen[$];
      bit was_ce;
      for (int i = 0; i < N + L; i++) begin
         if (i < N) drive(1'b1, i, 1'b0, int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768);
         else ien = 1'b0;
         if (i == 7) begin
            held = {oen, oaddr, odata, oovf};
            ice  = 1'b0;
            for (int c = 0; c < 3; c++) begin
               tick();
               n_vec++;
               if ({oen, oaddr, odata, oovf} !== held) begin
                  n_err++;
                  $display("FAIL stall_hold%0d: got %h want %h", c, {oen, oaddr, odata, oovf}, held);
               end
            end
            ice = 1'b1;
         end
         was_ce = ice;
         tick();
         if (was_ce && oen) seen.push_back(int'(oaddr));
         n_vec++;
         if ({oen, oaddr, odata, oovf} !== {exp_oen, exp_oaddr, exp_odata, exp_oovf}) begin
            n_err++;
            $display("FAIL stall_model: got %h want %h", {oen, oaddr, odata, oovf}, {exp_oen, exp_oaddr, exp_odata, exp_oovf});
         end
      end
      n_vec++;
      if (seen.size() != N) begin
         n_err++;
         $display("FAIL stall_count: got %0d outputs want %0d", seen.size(), N);
      end else begin
         for (int k = 0; k < N; k++) begin
            n_vec++;
            if (seen[k] != k) begin
               n_err++;
               $display("FAIL stall_order: got addr %0d want %0d", seen[k], k);
            end
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         ice = ($urandom_range(0, 9) != 0);
         drive($urandom_range(0, 3) != 0, int'($urandom_range(0, N - 1)), $urandom_range(0, 1) == 1,
               int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768);
         if ($urandom_range(0, 7) == 0) iaddr = '0;
         tick();
         n_vec++;
         if ({oen, oaddr, odata, oovf} !== {exp_oen, exp_oaddr, exp_odata, exp_oovf}) begin
            n_err++;
            $display("FAIL random_model: cycle %0d got %h want %h", i, {oen, oaddr, odata, oovf}, {exp_oen, exp_oaddr, exp_odata, exp_oovf});
         end
      end
      ice = 1'b1;
      ien = 1'b0;
      repeat (L) tick();
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, i, 1'b1, 20000, -20000);
         tick();
      end
      #2;
      irst_n = 1'b0;
      ien    = 1'b0;
      #1;
      n_vec++;
      if ({oen, oaddr, odata, oovf} !== '0) begin
         n_err++;
         $display("FAIL async_reset: got %h want 0", {oen, oaddr, odata, oovf});
      end
      tick();
      @(negedge iclk);
      irst_n = 1'b1;
      for (int c = 0; c < L + 2; c++) begin
         tick();
         n_vec++;
         if ({oen, oaddr, odata, oovf} !== {exp_oen, exp_oaddr, exp_odata, exp_oovf} || oen !== 1'b0) begin
            n_err++;
            $display("FAIL post_reset: got %h want %h", {oen, oaddr, odata, oovf}, {exp_oen, exp_oaddr, exp_odata, exp_oovf});
         end
      end
   endtask

   initial begin
      test_reset();
      test_identity();
      test_rotate45();
      test_inverse();
      test_saturation();
      test_stall();
      test_random();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
